// File: rtl/multi_motor_driver.sv
// N-channel soft-start H-bridge driver: per-channel duty ramping, reversal dead-time
// and PWM enable generation for L298-style bridge inputs.
module multi_motor_driver #(
  parameter int NUM_MOTORS = 2,
  parameter int PWM_BITS   = 8,
  parameter int RAMP_DIV   = 1250,
  parameter int DEADTIME   = 1250
) (
  input  logic                             clk_125mhz,
  input  logic                             reset,
  input  logic                             cmd_valid,
  input  logic [2*NUM_MOTORS-1:0]          cmd_mode,
  input  logic [PWM_BITS*NUM_MOTORS-1:0]   cmd_duty,
  output logic [2*NUM_MOTORS-1:0]          in,
  output logic [NUM_MOTORS-1:0]            en,
  output logic [NUM_MOTORS-1:0]            busy
);

  localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DT_W  = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

  localparam logic [1:0] MODE_COAST = 2'b00;
  localparam logic [1:0] MODE_REV   = 2'b10;
  localparam logic [1:0] MODE_BRAKE = 2'b11;

  typedef enum logic [1:0] {ST_COAST, ST_BRAKE, ST_RUN, ST_DEAD} state_t;

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic                ramp_tick;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    ramp_tick = (presc_q == PRE_W'(RAMP_DIV - 1));
    presc_d   = ramp_tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk_125mhz) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MOTORS; gi++) begin : g_ch
      state_t              state_q, state_d;
      logic [1:0]          tgt_mode_q, tgt_mode_d;
      logic [PWM_BITS-1:0] tgt_duty_q, tgt_duty_d;
      logic [PWM_BITS-1:0] cur_duty_q, cur_duty_d;
      logic                cur_dir_q, cur_dir_d;   // 0 = forward, 1 = reverse
      logic [DT_W-1:0]     dead_q, dead_d;
      logic [1:0]          in_q, in_d;
      logic                en_q, en_d;
      logic                busy_q, busy_d;
      logic                tgt_dir;

      always_comb begin
        tgt_mode_d = cmd_valid ? cmd_mode[2*gi +: 2] : tgt_mode_q;
        tgt_duty_d = cmd_valid ? cmd_duty[PWM_BITS*gi +: PWM_BITS] : tgt_duty_q;
        tgt_dir    = (tgt_mode_q == MODE_REV);
        state_d    = state_q;
        cur_duty_d = cur_duty_q;
        cur_dir_d  = cur_dir_q;
        dead_d     = dead_q;

        // Coast and brake bypass ramping and dead-time from any state.
        if (tgt_mode_q == MODE_COAST) begin
          state_d    = ST_COAST;
          cur_duty_d = '0;
          dead_d     = '0;
        end else if (tgt_mode_q == MODE_BRAKE) begin
          state_d    = ST_BRAKE;
          cur_duty_d = '0;
          dead_d     = '0;
        end else begin
          case (state_q)
            ST_COAST, ST_BRAKE: begin
              state_d    = ST_RUN;
              cur_dir_d  = tgt_dir;
              cur_duty_d = '0;
            end
            ST_RUN: begin
              if (tgt_dir == cur_dir_q) begin
                if (ramp_tick) begin
                  if (cur_duty_q < tgt_duty_q)
                    cur_duty_d = cur_duty_q + 1'b1;
                  else if (cur_duty_q > tgt_duty_q)
                    cur_duty_d = cur_duty_q - 1'b1;
                end
              end else if (cur_duty_q == '0) begin
                state_d = ST_DEAD;
                dead_d  = DT_W'(DEADTIME - 1);
              end else if (ramp_tick) begin
                cur_duty_d = cur_duty_q - 1'b1;
              end
            end
            ST_DEAD: begin
              if (dead_q == '0) begin
                state_d    = ST_RUN;
                cur_dir_d  = tgt_dir;
                cur_duty_d = '0;
              end else begin
                dead_d = dead_q - 1'b1;
              end
            end
            default: state_d = ST_COAST;
          endcase
        end

        // Pin encoding is {IN_B, IN_A}; forward drives IN_B.
        in_d = 2'b00;
        en_d = 1'b0;
        case (state_q)
          ST_BRAKE: begin
            in_d = 2'b11;
            en_d = 1'b1;
          end
          ST_RUN: begin
            in_d = cur_dir_q ? 2'b01 : 2'b10;
            en_d = (pwm_cnt_q < cur_duty_q);
          end
          default: begin
            in_d = 2'b00;
            en_d = 1'b0;
          end
        endcase
        busy_d = (cur_duty_q != tgt_duty_q) || (state_q == ST_DEAD);
      end

      always_ff @(posedge clk_125mhz) begin
        if (reset) begin
          state_q    <= ST_COAST;
          tgt_mode_q <= MODE_COAST;
          tgt_duty_q <= '0;
          cur_duty_q <= '0;
          cur_dir_q  <= 1'b0;
          dead_q     <= '0;
          in_q       <= 2'b00;
          en_q       <= 1'b0;
          busy_q     <= 1'b0;
        end else begin
          state_q    <= state_d;
          tgt_mode_q <= tgt_mode_d;
          tgt_duty_q <= tgt_duty_d;
          cur_duty_q <= cur_duty_d;
          cur_dir_q  <= cur_dir_d;
          dead_q     <= dead_d;
          in_q       <= in_d;
          en_q       <= en_d;
          busy_q     <= busy_d;
        end
      end

      assign in[2*gi +: 2] = in_q;
      assign en[gi]        = en_q;
      assign busy[gi]      = busy_q;
    end
  endgenerate

endmodule

// File: tb/tb_multi_motor_driver.sv
// Directed bench for multi_motor_driver with a short PWM period, fast ramp and
// short dead-time; every command lands on a ramp-tick edge so timings are exact.
module tb_multi_motor_driver;

  localparam int NM = 2;
  localparam int PB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic [2*NM-1:0]   cmd_mode;
  logic [PB*NM-1:0]  cmd_duty;
  logic [2*NM-1:0]   in_w;
  logic [NM-1:0]     en_w;
  logic [NM-1:0]     busy_w;

  int cyc   = 0;
  int nvec  = 0;
  int nfail = 0;

  multi_motor_driver #(
    .NUM_MOTORS(NM), .PWM_BITS(PB), .RAMP_DIV(4), .DEADTIME(8)
  ) dut (
    .clk_125mhz(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_mode(cmd_mode),
    .cmd_duty(cmd_duty),
    .in(in_w),
    .en(en_w),
    .busy(busy_w)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issue a command so that it is latched on a ramp-tick edge; e returns that edge.
  task automatic send(input logic [3:0] mode, input logic [7:0] duty, output int e);
    for (int k = 0; k < 4 && ((cyc + 1) % 4) != 3; k++) begin
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_duty  = duty;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    e = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2, e3, e4, e5, e6, e7, e8, n, hi0, hi1, bad;
    reset = 1'b1; cmd_valid = 1'b0; cmd_mode = '0; cmd_duty = '0;

    // Reset held for edges 1..3 with a command pulsed in the middle.
    wait_to(1);
    cmd_valid = 1'b1; cmd_mode = 4'b0101; cmd_duty = 8'h88;
    wait_to(2);
    cmd_valid = 1'b0;
    wait_to(3);
    reset = 1'b0;
    check("rst_in", in_w, 4'b0000);
    check("rst_en", en_w, 2'b00);
    check("rst_busy", busy_w, 2'b00);
    wait_to(12);
    check("rst_cmd_ignored_in", in_w, 4'b0000);
    check("rst_cmd_ignored_busy", busy_w, 2'b00);

    // ch0 forward, duty 8, from coast.
    send(4'b0001, 8'h08, e);
    wait_to(e + 1);
    check("fwd8_in_lat1", in_w[1:0], 2'b00);
    check("fwd8_busy_start", busy_w[0], 1'b1);
    wait_to(e + 2);
    check("fwd8_in", in_w[1:0], 2'b10);
    wait_to(e + 32);
    check("fwd8_busy_e32", busy_w[0], 1'b1);
    wait_to(e + 33);
    check("fwd8_busy_e33", busy_w[0], 1'b0);
    wait_to(e + 34);
    hi0 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (en_w[0]) hi0++;
      if (in_w[1:0] != 2'b10) bad++;
      @(posedge clk); #1;
    end
    check("fwd8_en_high_16", hi0, 8);
    check("fwd8_in_steady", bad, 0);

    // Reverse to duty 4: ramp down, dead-time, ramp up.
    send(4'b0010, 8'h04, e2);
    wait_to(e2 + 33);
    check("rev_in_before_dead", in_w[1:0], 2'b10);
    wait_to(e2 + 34);
    n = 0; hi0 = 0;
    while (in_w[1:0] == 2'b00 && n < 20) begin
      n++;
      if (en_w[0]) hi0++;
      @(posedge clk); #1;
    end
    check("rev_dead_len", n, 8);
    check("rev_dead_en", hi0, 0);
    check("rev_in_after_dead", in_w[1:0], 2'b01);
    wait_to(e2 + 56);
    check("rev_busy_e56", busy_w[0], 1'b1);
    wait_to(e2 + 57);
    check("rev_busy_e57", busy_w[0], 1'b0);

    // ch1 forward 10 while ch0 holds reverse 4; then brake ch1 mid-ramp.
    send(4'b0110, 8'hA4, e3);
    wait_to(e3 + 14);
    send(4'b1110, 8'h04, e4);
    wait_to(e4 + 1);
    check("brk_in1_lat1", in_w[3:2], 2'b10);
    check("brk_busy1_lat1", busy_w[1], 1'b1);
    wait_to(e4 + 2);
    check("brk_in1", in_w[3:2], 2'b11);
    check("brk_en1", en_w[1], 1'b1);
    check("brk_busy1", busy_w[1], 1'b0);
    check("brk_ch0_in", in_w[1:0], 2'b01);
    check("brk_ch0_busy", busy_w[0], 1'b0);

    // ch0 reverse -> forward 4, then coast during the dead-time.
    send(4'b1101, 8'h04, e5);
    wait_to(e5 + 19);
    check("dead_in0", in_w[1:0], 2'b00);
    check("dead_busy0", busy_w[0], 1'b1);
    send(4'b1100, 8'h00, e6);
    check("coast_edge", e6, e5 + 20);
    wait_to(e6 + 2);
    check("coast_busy0", busy_w[0], 1'b0);
    check("coast_in0", in_w[1:0], 2'b00);
    check("coast_brake_kept", in_w[3:2], 2'b11);
    send(4'b1101, 8'h02, e7);
    wait_to(e7 + 2);
    check("fwd2_no_dead", in_w[1:0], 2'b10);
    wait_to(e7 + 8);
    check("fwd2_busy_e8", busy_w[0], 1'b1);
    wait_to(e7 + 9);
    check("fwd2_busy_e9", busy_w[0], 1'b0);

    // ch0 duty 15 (max), ch1 forward at duty 0.
    send(4'b0101, 8'h0F, e8);
    wait_to(e8 + 54);
    check("max_busy", busy_w, 2'b00);
    hi0 = 0; hi1 = 0; bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (en_w[0]) hi0++;
      if (en_w[1]) hi1++;
      if (in_w != 4'b1010) bad++;
      @(posedge clk); #1;
    end
    check("max_en0_high_16", hi0, 15);
    check("zero_en1_high_16", hi1, 0);
    check("max_in_steady", bad, 0);

    // Reset while running clears everything at once.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_in", in_w, 4'b0000);
    check("mid_rst_en", en_w, 2'b00);
    check("mid_rst_busy", busy_w, 2'b00);
    repeat (6) begin @(posedge clk); #1; end
    check("mid_rst_hold_in", in_w, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/multi_motor_driver.md
Name: multi_motor_driver

Overview:
- N-channel H-bridge driver and parametrised successor of the two-motor direct-decode driver.
- Each channel takes a latched mode and target duty, and generates its own PWM enable internally.
- Duty ramps toward the target at a fixed slew rate (soft start/stop).
- A FWD<->REV reversal ramps down to zero, then holds a coast dead-time before the new direction drives.
- Sits between the command/sequencing logic and the L298-style bridge pins.

Parameters:
- NUM_MOTORS, 2, number of bridge channels (1..8).
- PWM_BITS, 8, duty and PWM counter width; PWM period = 2^PWM_BITS clocks.
- RAMP_DIV, 1250, clocks per ramp step; duty moves 1 LSB per step (>=2).
- DEADTIME, 1250, coast clocks inserted on direction reversal (>=1).

Ports:
- clk_125mhz  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  single-cycle strobe; latches cmd_mode and cmd_duty for all channels.
- cmd_mode  in  2*NUM_MOTORS  per channel k, bits [2k+1:2k]: 00 coast, 01 forward, 10 reverse, 11 brake.
- cmd_duty  in  PWM_BITS*NUM_MOTORS  per channel target duty, slice [k*PWM_BITS +: PWM_BITS].
- in  out  2*NUM_MOTORS  bridge inputs; in[2k] = IN_A, in[2k+1] = IN_B for channel k.
- en  out  NUM_MOTORS  bridge enable (PWM) per channel.
- busy  out  NUM_MOTORS  channel k is ramping or in dead-time (cur_duty != tgt_duty, or state DEAD).

Behaviour:
- Reset (synchronous, active-high):
  - All outputs = 0.
  - Per channel: state COAST, tgt_mode 00, tgt_duty 0, cur_duty 0, cur_dir FWD.
  - PWM counter, prescaler and dead-time counters = 0.
  - Reset asserted mid-ramp or mid-dead-time aborts immediately to the reset state.
- Shared counters:
  - pwm_cnt is a free-running PWM_BITS counter that wraps 2^PWM_BITS-1 -> 0.
  - The prescaler counts 0..RAMP_DIV-1. ramp_tick is 1 for the single cycle where the prescaler = RAMP_DIV-1.
- Command latch:
  - cmd_valid=1 writes tgt_mode and tgt_duty for every channel at that edge.
  - A new command overrides any in-flight target, including during DEAD.
- Per-channel FSM, with states COAST, BRAKE, RUN and DEAD:
  - COAST: cur_duty forced to 0.
    - Leaves COAST when tgt_mode is FWD or REV: cur_dir = tgt direction, go to RUN, ramp up from 0.
  - BRAKE: cur_duty forced to 0.
    - Leaves BRAKE on FWD or REV exactly as COAST does.
  - Coast and brake override every state and are applied on the edge after the latch, with no ramp and no dead-time.
  - RUN, target direction equal to cur_dir:
    - On each ramp_tick, cur_duty steps by +1 or -1 toward tgt_duty.
    - When equal, cur_duty holds.
  - RUN, target direction opposite to cur_dir:
    - On each ramp_tick, cur_duty decrements toward 0.
    - When cur_duty = 0, enter DEAD with the dead-time counter loaded to DEADTIME-1.
  - DEAD: coasts for exactly DEADTIME clocks, then handles the target:
    - If the target is still FWD or REV: cur_dir = tgt direction, go to RUN with cur_duty 0.
    - If the target has become opposite again: another DEAD pass is not required.
    - A coast or brake target exits DEAD immediately.
  - A target with FWD/REV and tgt_duty 0: stays in RUN with en=0 and in driven to that direction.
- Outputs (registered, one-clock latency from state/counters):
  - COAST or DEAD: in = 00, en = 0.
  - BRAKE: in = 11, en = 1.
  - RUN FWD: {IN_B, IN_A} = 10 (IN_A=0, IN_B=1); en = (pwm_cnt < cur_duty).
  - RUN REV: IN_A=1, IN_B=0; en = (pwm_cnt < cur_duty).
  - Duty all-ones gives (2^PWM_BITS-1)/2^PWM_BITS high time; 100% is not reachable by design.
- Invariants:
  - in[2k] and in[2k+1] are never both 1 while en is pulsing.
  - The output never goes directly from FWD to REV without a DEAD interval of at least DEADTIME clocks.
  - Channels are independent; simultaneous events on different channels do not interact.

Test Plan (PWM_BITS=4, RAMP_DIV=4, DEADTIME=8, NUM_MOTORS=2):
- Reset held for 3 clocks, with cmd_valid pulsed during reset -> in=0000, en=00, busy=00; the command is ignored.
- ch0 FWD, duty 8, from COAST -> cur_duty reaches 8 after 8 ramp_ticks (32 clocks); en0 high 8 of every 16 clocks; in[1:0]=10; busy0 drops once duty = 8.
- ch0 RUN FWD 8, then REV 4 -> 8 down-steps (32 clocks) to 0; in[1:0]=00 and en0=0 for exactly 8 clocks; then in[1:0]=01 and ramp to 4 in 16 clocks.
- BRAKE sent mid-ramp on ch1 -> next edge plus one: in[3:2]=11, en1=1, cur_duty 0; ch0 unaffected.
- COAST sent during ch0 DEAD -> immediate exit to COAST; a later FWD 2 ramps from 0 with no further dead-time.
- ch0 FWD duty 15 -> en0 low exactly 1 clock per 16; ch1 duty 0 in FWD -> en1 constant 0, in[3:2]=10.
